// File: rtl/cic_pkg.sv
// Shared CIC decimator types: rate-mode selector, rate word type and a clog2 helper
// used by both the integrator chain and the decimating back-end.
package cic_pkg;

  typedef enum logic {
    RATE_FIXED    = 1'b0,
    RATE_VARIABLE = 1'b1
  } rate_mode_e;

  localparam int unsigned CIC_RATE_DW_DEF = 32;

  typedef logic [CIC_RATE_DW_DEF-1:0] cic_rate_t;

  function automatic int unsigned cic_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/cic_decim_back_end_if.sv
// Streaming bus of the CIC back-end: input samples, rate loads and decimated output.
// The slave modport is the filter's view; the master modport is the producer/consumer side.
interface cic_decim_back_end_if #(
  parameter int INP_DW  = 32,
  parameter int OUT_DW  = 32,
  parameter int RATE_DW = 32
);

  logic signed [INP_DW-1:0]  s_axis_in_tdata;
  logic                      s_axis_in_tvalid;
  logic        [RATE_DW-1:0] s_axis_rate_tdata;
  logic                      s_axis_rate_tvalid;
  logic signed [OUT_DW-1:0]  m_axis_out_tdata;
  logic                      m_axis_out_tvalid;

  modport master (
    output s_axis_in_tdata, s_axis_in_tvalid, s_axis_rate_tdata, s_axis_rate_tvalid,
    input  m_axis_out_tdata, m_axis_out_tvalid
  );

  modport slave (
    input  s_axis_in_tdata, s_axis_in_tvalid, s_axis_rate_tdata, s_axis_rate_tvalid,
    output m_axis_out_tdata, m_axis_out_tvalid
  );

endinterface

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x[n-M] evaluated only on input strobes, modulo 2^W.
// Output data and strobe are registered together; data holds between strobes.
module cic_comb_stage #(
  parameter int W = 32,
  parameter int M = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic signed [W-1:0] out_data
);

  logic signed [W-1:0] dly_q [M];
  logic signed [W-1:0] dly_d [M];
  logic signed [W-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    dly_d       = dly_q;
    out_data_d  = out_data_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_data_d = in_data - dly_q[M-1];
      dly_d[0]   = in_data;
      for (int i = 1; i < M; i++) dly_d[i] = dly_q[i-1];
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the delay line is short and must start from zero, so it is reset like any other flop.
      for (int i = 0; i < M; i++) dly_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/cic_decim_back_end.sv
// CIC decimator back-end: downsample the integrator output by R (fixed or loadable),
// run CIC_N comb stages of delay CIC_M, keep the OUT_DW MSBs in an output register.
module cic_decim_back_end
  import cic_pkg::*;
#(
  parameter int INP_DW        = 32,
  parameter int OUT_DW        = 32,
  parameter int RATE_DW       = 32,
  parameter int CIC_R         = 10,
  parameter int CIC_N         = 7,
  parameter int CIC_M         = 1,
  parameter int VARIABLE_RATE = 1
) (
  input logic                  clk,
  input logic                  reset,
  cic_decim_back_end_if.slave  bus
);

  localparam rate_mode_e RATE_MODE = (VARIABLE_RATE != 0) ? RATE_VARIABLE : RATE_FIXED;

  logic [RATE_DW-1:0]       rate_eff, cnt_eff;
  logic [RATE_DW-1:0]       cnt_q, cnt_d;
  logic                     keep;
  logic signed [INP_DW-1:0] ds_data_q, ds_data_d;
  logic                     ds_valid_q, ds_valid_d;

  // A rate load applies to the sample of the same cycle and restarts the phase at zero.
  if (RATE_MODE == RATE_VARIABLE) begin : g_var_rate
    logic [RATE_DW-1:0] rate_q, rate_d;

    always_comb begin
      rate_d = bus.s_axis_rate_tvalid ? bus.s_axis_rate_tdata : rate_q;
    end

    always_ff @(posedge clk) begin
      if (reset) rate_q <= RATE_DW'(CIC_R);
      else       rate_q <= rate_d;
    end

    assign rate_eff = rate_d;
    assign cnt_eff  = bus.s_axis_rate_tvalid ? '0 : cnt_q;
  end else begin : g_fix_rate
    assign rate_eff = RATE_DW'(CIC_R);
    assign cnt_eff  = cnt_q;
  end

  always_comb begin
    keep       = bus.s_axis_in_tvalid &&
                 ((rate_eff <= RATE_DW'(1)) || (cnt_eff == rate_eff - RATE_DW'(1)));
    cnt_d      = cnt_eff;
    ds_data_d  = ds_data_q;
    ds_valid_d = keep;
    if (bus.s_axis_in_tvalid) cnt_d = keep ? '0 : cnt_eff + RATE_DW'(1);
    if (keep)                 ds_data_d = bus.s_axis_in_tdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      ds_data_q  <= '0;
      ds_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ds_data_q  <= ds_data_d;
      ds_valid_q <= ds_valid_d;
    end
  end

  logic [CIC_N:0]           stg_valid;
  logic signed [INP_DW-1:0] stg_data [CIC_N+1];

  assign stg_valid[0] = ds_valid_q;
  assign stg_data[0]  = ds_data_q;

  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    cic_comb_stage #(
      .W (INP_DW),
      .M (CIC_M)
    ) u_comb (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (stg_valid[k]),
      .in_data   (stg_data[k]),
      .out_valid (stg_valid[k+1]),
      .out_data  (stg_data[k+1])
    );
  end

  logic signed [OUT_DW-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;

  always_comb begin
    out_valid_d = stg_valid[CIC_N];
    out_data_d  = stg_valid[CIC_N] ? stg_data[CIC_N][INP_DW-1 -: OUT_DW] : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.m_axis_out_tdata  = out_data_q;
  assign bus.m_axis_out_tvalid = out_valid_q;

endmodule

// File: tb/tb_cic_decim_back_end.sv
// Directed bench for cic_decim_back_end: five configurations share clock and reset,
// each exercised by a hand-computed vector sequence.
module tb_cic_decim_back_end;

  logic clk;
  logic reset;

  int n_vec;
  int n_err;

  cic_decim_back_end_if #(.INP_DW(16), .OUT_DW(16), .RATE_DW(32)) f_if ();
  cic_decim_back_end_if #(.INP_DW(16), .OUT_DW(16), .RATE_DW(32)) v_if ();
  cic_decim_back_end_if #(.INP_DW(16), .OUT_DW(16), .RATE_DW(32)) c_if ();
  cic_decim_back_end_if #(.INP_DW(8),  .OUT_DW(8),  .RATE_DW(32)) w_if ();
  cic_decim_back_end_if #(.INP_DW(16), .OUT_DW(8),  .RATE_DW(32)) t_if ();

  cic_decim_back_end #(.INP_DW(16), .OUT_DW(16), .RATE_DW(32), .CIC_R(4), .CIC_N(1),
                       .CIC_M(1), .VARIABLE_RATE(0))
    u_fix (.clk(clk), .reset(reset), .bus(f_if.slave));

  cic_decim_back_end #(.INP_DW(16), .OUT_DW(16), .RATE_DW(32), .CIC_R(4), .CIC_N(1),
                       .CIC_M(1), .VARIABLE_RATE(1))
    u_var (.clk(clk), .reset(reset), .bus(v_if.slave));

  cic_decim_back_end #(.INP_DW(16), .OUT_DW(16), .RATE_DW(32), .CIC_R(1), .CIC_N(2),
                       .CIC_M(2), .VARIABLE_RATE(1))
    u_comb (.clk(clk), .reset(reset), .bus(c_if.slave));

  cic_decim_back_end #(.INP_DW(8), .OUT_DW(8), .RATE_DW(32), .CIC_R(1), .CIC_N(1),
                       .CIC_M(1), .VARIABLE_RATE(1))
    u_wrap (.clk(clk), .reset(reset), .bus(w_if.slave));

  cic_decim_back_end #(.INP_DW(16), .OUT_DW(8), .RATE_DW(32), .CIC_R(1), .CIC_N(1),
                       .CIC_M(1), .VARIABLE_RATE(1))
    u_trunc (.clk(clk), .reset(reset), .bus(t_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    f_if.s_axis_in_tvalid = 1'b0; f_if.s_axis_in_tdata = '0;
    f_if.s_axis_rate_tvalid = 1'b0; f_if.s_axis_rate_tdata = '0;
    v_if.s_axis_in_tvalid = 1'b0; v_if.s_axis_in_tdata = '0;
    v_if.s_axis_rate_tvalid = 1'b0; v_if.s_axis_rate_tdata = '0;
    c_if.s_axis_in_tvalid = 1'b0; c_if.s_axis_in_tdata = '0;
    c_if.s_axis_rate_tvalid = 1'b0; c_if.s_axis_rate_tdata = '0;
    w_if.s_axis_in_tvalid = 1'b0; w_if.s_axis_in_tdata = '0;
    w_if.s_axis_rate_tvalid = 1'b0; w_if.s_axis_rate_tdata = '0;
    t_if.s_axis_in_tvalid = 1'b0; t_if.s_axis_in_tdata = '0;
    t_if.s_axis_rate_tvalid = 1'b0; t_if.s_axis_rate_tdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fix_v"},   f_if.m_axis_out_tvalid, 0);
    chk({tag, "_fix_d"},   f_if.m_axis_out_tdata,  0);
    chk({tag, "_var_v"},   v_if.m_axis_out_tvalid, 0);
    chk({tag, "_var_d"},   v_if.m_axis_out_tdata,  0);
    chk({tag, "_comb_v"},  c_if.m_axis_out_tvalid, 0);
    chk({tag, "_comb_d"},  c_if.m_axis_out_tdata,  0);
    chk({tag, "_wrap_v"},  w_if.m_axis_out_tvalid, 0);
    chk({tag, "_wrap_d"},  w_if.m_axis_out_tdata,  0);
    chk({tag, "_trunc_v"}, t_if.m_axis_out_tvalid, 0);
    chk({tag, "_trunc_d"}, t_if.m_axis_out_tdata,  0);
  endtask

  // Reset with random activity on every input, then one idle cycle after release.
  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_if.s_axis_in_tvalid = 1'b1; f_if.s_axis_in_tdata = 16'($urandom());
      v_if.s_axis_in_tvalid = 1'b1; v_if.s_axis_in_tdata = 16'($urandom());
      v_if.s_axis_rate_tvalid = 1'b1; v_if.s_axis_rate_tdata = $urandom_range(0, 9);
      c_if.s_axis_in_tvalid = 1'b1; c_if.s_axis_in_tdata = 16'($urandom());
      w_if.s_axis_in_tvalid = 1'b1; w_if.s_axis_in_tdata = 8'($urandom());
      t_if.s_axis_in_tvalid = 1'b1; t_if.s_axis_in_tdata = 16'($urandom());
      tick();
      chk_all_zero("in_reset");
    end
    reset = 1'b0;
    idle_all();
    tick();
    chk_all_zero("post_reset");
  endtask

  logic exp_v;
  int   exp_d;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle_all();
    do_reset();

    // Rate register comes out of reset at CIC_R=4: inputs 1..4 give one output, value 4.
    for (int c = 1; c <= 8; c++) begin
      v_if.s_axis_in_tvalid = (c <= 4);
      v_if.s_axis_in_tdata  = 16'(c);
      tick();
      exp_v = (c == 6);
      chk("rate_rst_valid", v_if.m_axis_out_tvalid, 32'(exp_v));
      if (exp_v) chk("rate_rst_data", v_if.m_axis_out_tdata, 4);
    end
    idle_all();

    // Fixed R=4, continuous 1..12: kept 4,8,12 -> outputs 4,4,4 two edges after each keep.
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      f_if.s_axis_in_tvalid = (c <= 12);
      f_if.s_axis_in_tdata  = 16'(c);
      tick();
      exp_v = (c == 6) || (c == 10) || (c == 14);
      chk("fix_valid", f_if.m_axis_out_tvalid, 32'(exp_v));
      if (exp_v) chk("fix_data", f_if.m_axis_out_tdata, 4);
    end
    chk("fix_hold", f_if.m_axis_out_tdata, 4);
    idle_all();

    // Gapped stream: sample k on cycle 2k-1; keeps on cycles 7,15,23 -> strobes 9,17,25.
    do_reset();
    for (int c = 1; c <= 28; c++) begin
      f_if.s_axis_in_tvalid = (c % 2 == 1) && (c <= 23);
      f_if.s_axis_in_tdata  = 16'((c + 1) / 2);
      tick();
      exp_v = (c == 9) || (c == 17) || (c == 25);
      chk("gap_valid", f_if.m_axis_out_tvalid, 32'(exp_v));
      if (exp_v) chk("gap_data", f_if.m_axis_out_tdata, 4);
    end
    idle_all();

    // Load rate 2 together with sample 3: kept 4,6,8,10 -> outputs 4,2,2,2.
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      v_if.s_axis_in_tvalid   = (c <= 10);
      v_if.s_axis_in_tdata    = 16'(c);
      v_if.s_axis_rate_tvalid = (c == 3);
      v_if.s_axis_rate_tdata  = 32'd2;
      tick();
      exp_v = (c == 6) || (c == 8) || (c == 10) || (c == 12);
      exp_d = (c == 6) ? 4 : 2;
      chk("var_valid", v_if.m_axis_out_tvalid, 32'(exp_v));
      if (exp_v) chk("var_data", v_if.m_axis_out_tdata, exp_d);
    end
    idle_all();

    // Rate 0 loaded with the first sample: pass-through of 5,7,10 -> 5,2,3.
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      v_if.s_axis_in_tvalid   = (c <= 3);
      v_if.s_axis_in_tdata    = (c == 1) ? 16'sd5 : (c == 2) ? 16'sd7 : 16'sd10;
      v_if.s_axis_rate_tvalid = (c == 1);
      v_if.s_axis_rate_tdata  = 32'd0;
      tick();
      exp_v = (c >= 3) && (c <= 5);
      exp_d = (c == 3) ? 5 : (c == 4) ? 2 : 3;
      chk("pass_valid", v_if.m_axis_out_tvalid, 32'(exp_v));
      if (exp_v) chk("pass_data", v_if.m_axis_out_tdata, exp_d);
    end
    idle_all();

    // (1 - z^-2)^2 impulse response: 1,0,-2,0,1,0,0, three edges after each input.
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      c_if.s_axis_in_tvalid = (c <= 7);
      c_if.s_axis_in_tdata  = (c == 1) ? 16'sd1 : 16'sd0;
      tick();
      exp_v = (c >= 4);
      case (c)
        4:       exp_d = 1;
        6:       exp_d = -2;
        8:       exp_d = 1;
        default: exp_d = 0;
      endcase
      chk("comb_valid", c_if.m_axis_out_tvalid, 32'(exp_v));
      if (exp_v) chk("comb_data", c_if.m_axis_out_tdata, exp_d);
    end
    idle_all();

    // Reset while the impulse is in flight: nothing may come out afterwards.
    c_if.s_axis_in_tvalid = 1'b1;
    c_if.s_axis_in_tdata  = 16'sd1;
    tick();
    idle_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst_valid", c_if.m_axis_out_tvalid, 0);
      chk("midrst_data",  c_if.m_axis_out_tdata,  0);
    end

    // 8-bit wrap: 127 then -128 -> 127 then (-128-127) mod 256 = 1.
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      w_if.s_axis_in_tvalid = (c <= 2);
      w_if.s_axis_in_tdata  = (c == 1) ? 8'sd127 : -8'sd128;
      tick();
      exp_v = (c >= 3);
      exp_d = (c == 3) ? 127 : 1;
      chk("wrap_valid", w_if.m_axis_out_tvalid, 32'(exp_v));
      if (exp_v) chk("wrap_data", w_if.m_axis_out_tdata, exp_d);
    end
    idle_all();

    // 16 -> 8 bit MSB truncation: 0x1234 -> 0x12, then 0x1334-0x1234=0x0100 -> 0x01, held.
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      t_if.s_axis_in_tvalid = (c <= 2);
      t_if.s_axis_in_tdata  = (c == 1) ? 16'sh1234 : 16'sh1334;
      tick();
      exp_v = (c == 3) || (c == 4);
      exp_d = (c == 3) ? 32'h12 : 32'h01;
      chk("trunc_valid", t_if.m_axis_out_tvalid, 32'(exp_v));
      chk("trunc_data",  t_if.m_axis_out_tdata,  (c < 3) ? 0 : exp_d);
    end
    idle_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
